// File: rtl/param_mode_counter.sv
// param_mode_counter: WIDTH-bit sequence generator with four run-time modes
// (binary up/down modulo MODULUS, Gray up, Johnson). It has a clock enable,
// a synchronous load and a registered terminal-count pulse. out and TC are
// registered and reflect the count produced by the same edge.
module param_mode_counter #(
    parameter int unsigned WIDTH   = 3,
    parameter int unsigned MODULUS = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EN,
    input  logic [1:0]       MODE,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VAL,
    output logic [WIDTH-1:0] out,
    output logic             TC
);

    typedef enum logic [1:0] {
        MODE_UP      = 2'b00,
        MODE_DOWN    = 2'b01,
        MODE_GRAY    = 2'b10,
        MODE_JOHNSON = 2'b11
    } mode_t;

    // One extra bit so MODULUS = 2^WIDTH stays representable in the clamp compare
    localparam int unsigned     XW           = WIDTH + 1;
    localparam logic [XW-1:0]   MODULUS_X    = XW'(MODULUS);
    localparam logic [WIDTH-1:0] BIN_MAX     = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] JOHNSON_END = {1'b1, {(WIDTH-1){1'b0}}};

    mode_t            r_mode_q;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_out;
    logic             r_tc;

    mode_t            w_mode;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] w_out_nxt;
    logic             w_tc_nxt;
    logic             w_load_big;

    assign w_mode     = mode_t'(MODE);
    assign w_load_big = (XW'(LOAD_VAL) >= MODULUS_X);

    // Next count and wrap detection; priority is mode change > load > enable > hold
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_tc_nxt  = 1'b0;
        if (w_mode != r_mode_q) begin
            w_cnt_nxt = '0;
        end else if (LOAD) begin
            case (w_mode)
                MODE_UP, MODE_DOWN: w_cnt_nxt = w_load_big ? BIN_MAX : LOAD_VAL;
                MODE_GRAY:          w_cnt_nxt = LOAD_VAL;
                default:            w_cnt_nxt = '0;
            endcase
        end else if (EN) begin
            case (w_mode)
                MODE_UP: begin
                    w_tc_nxt  = (r_cnt == BIN_MAX);
                    w_cnt_nxt = w_tc_nxt ? '0 : r_cnt + WIDTH'(1);
                end
                MODE_DOWN: begin
                    w_tc_nxt  = (r_cnt == '0);
                    w_cnt_nxt = w_tc_nxt ? BIN_MAX : r_cnt - WIDTH'(1);
                end
                MODE_GRAY: begin
                    w_tc_nxt  = (r_cnt == '1);
                    w_cnt_nxt = r_cnt + WIDTH'(1);
                end
                default: begin
                    w_tc_nxt  = (r_cnt == JOHNSON_END);
                    w_cnt_nxt = {r_cnt[WIDTH-2:0], ~r_cnt[WIDTH-1]};
                end
            endcase
        end
    end

    // Output encoding of the next count; mode_q always follows MODE after an edge
    always_comb begin
        w_out_nxt = w_cnt_nxt;
        if (w_mode == MODE_GRAY) begin
            w_out_nxt = w_cnt_nxt ^ (w_cnt_nxt >> 1);
        end
    end

    // State and output registers with synchronous active-high reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_cnt    <= '0;
            r_out    <= '0;
            r_tc     <= 1'b0;
            r_mode_q <= w_mode;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_out    <= w_out_nxt;
            r_tc     <= w_tc_nxt;
            r_mode_q <= w_mode;
        end
    end

    assign out = r_out;
    assign TC  = r_tc;

endmodule

// File: tb/tb_param_mode_counter.sv
// Scoreboard bench for param_mode_counter: a default instance (WIDTH=3,
// MODULUS=8) and a MODULUS=6 instance share all inputs. The driver pushes
// hand-computed expectations; a monitor pops and compares on the falling edge.
module tb_param_mode_counter;

    logic       CLK;
    logic       RESET;
    logic       EN;
    logic [1:0] MODE;
    logic       LOAD;
    logic [2:0] LOAD_VAL;
    logic [2:0] out8;
    logic       tc8;
    logic [2:0] out6;
    logic       tc6;

    typedef struct {
        bit         sel6;
        logic [2:0] out;
        logic       tc;
        string      name;
    } exp_t;

    exp_t q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    param_mode_counter #(.WIDTH(3), .MODULUS(8)) dut8 (
        .CLK(CLK), .RESET(RESET), .EN(EN), .MODE(MODE), .LOAD(LOAD),
        .LOAD_VAL(LOAD_VAL), .out(out8), .TC(tc8)
    );

    param_mode_counter #(.WIDTH(3), .MODULUS(6)) dut6 (
        .CLK(CLK), .RESET(RESET), .EN(EN), .MODE(MODE), .LOAD(LOAD),
        .LOAD_VAL(LOAD_VAL), .out(out6), .TC(tc6)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Monitor: compare every pending expectation against the selected instance
    always @(negedge CLK) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [2:0] a_out;
            logic       a_tc;
            e     = q.pop_front();
            a_out = e.sel6 ? out6 : out8;
            a_tc  = e.sel6 ? tc6 : tc8;
            n_total++;
            if (a_out === e.out && a_tc === e.tc) begin
                n_pass++;
            end else begin
                $display("FAIL %s (%s): out=%b tc=%b, expected out=%b tc=%b",
                         e.name, e.sel6 ? "mod6" : "mod8", a_out, a_tc, e.out, e.tc);
            end
        end
    end

    // Apply one edge of stimulus and queue the expected post-edge outputs
    task automatic step(input logic rst, input logic en, input logic [1:0] md,
                        input logic ld, input logic [2:0] lv,
                        input bit c8, input logic [2:0] o8, input logic t8,
                        input bit c6, input logic [2:0] o6, input logic t6,
                        input string nm);
        exp_t e;
        RESET    = rst;
        EN       = en;
        MODE     = md;
        LOAD     = ld;
        LOAD_VAL = lv;
        @(posedge CLK);
        #1;
        if (c8) begin
            e.sel6 = 1'b0; e.out = o8; e.tc = t8; e.name = nm;
            q.push_back(e);
        end
        if (c6) begin
            e.sel6 = 1'b1; e.out = o6; e.tc = t6; e.name = nm;
            q.push_back(e);
        end
    endtask

    // Mod-8 only step helper
    task automatic s8(input logic rst, input logic en, input logic [1:0] md,
                      input logic ld, input logic [2:0] lv,
                      input logic [2:0] o8, input logic t8, input string nm);
        step(rst, en, md, ld, lv, 1'b1, o8, t8, 1'b0, 3'd0, 1'b0, nm);
    endtask

    logic [2:0] up_exp[10]   = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2};
    logic [2:0] dn6_exp[7]   = '{3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd5};
    logic [2:0] dn8_exp[7]   = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1};
    logic [2:0] gray_exp[8]  = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
    logic [2:0] john_exp[6]  = '{3'b001, 3'b011, 3'b111, 3'b110, 3'b100, 3'b000};

    initial begin
        RESET = 1'b1; EN = 1'b0; MODE = 2'b00; LOAD = 1'b0; LOAD_VAL = 3'd0;

        // Reset state on both instances
        step(1, 0, 2'b00, 0, 3'd0, 1, 3'd0, 0, 1, 3'd0, 0, "reset0");
        step(1, 0, 2'b00, 0, 3'd0, 1, 3'd0, 0, 1, 3'd0, 0, "reset1");

        // Binary up modulo 8, wrap pulse after 7->0
        for (int i = 0; i < 10; i++)
            s8(0, 1, 2'b00, 0, 3'd0, up_exp[i], (i == 7), $sformatf("up%0d", i));

        // Binary down: modulo 6 wraps 0->5 on the first and last edges
        step(1, 0, 2'b01, 0, 3'd0, 1, 3'd0, 0, 1, 3'd0, 0, "reset_down");
        for (int i = 0; i < 7; i++)
            step(0, 1, 2'b01, 0, 3'd0, 1, dn8_exp[i], (i == 0),
                 1, dn6_exp[i], (i == 0 || i == 6), $sformatf("down%0d", i));
        step(0, 1, 2'b01, 1, 3'd7, 1, 3'd7, 0, 1, 3'd5, 0, "down_load_clamp");
        step(0, 0, 2'b01, 0, 3'd0, 1, 3'd7, 0, 1, 3'd5, 0, "down_hold");

        // Gray up over the full 2^WIDTH cycle
        s8(1, 0, 2'b10, 0, 3'd0, 3'd0, 0, "reset_gray");
        for (int i = 0; i < 8; i++)
            s8(0, 1, 2'b10, 0, 3'd0, gray_exp[i], (i == 7), $sformatf("gray%0d", i));
        s8(0, 1, 2'b10, 1, 3'd5, 3'b111, 0, "gray_load5");
        s8(0, 1, 2'b10, 0, 3'd0, 3'b101, 0, "gray_after_load");

        // Mode change from up at 3 into Johnson, then a full twisted-ring cycle
        s8(1, 0, 2'b00, 0, 3'd0, 3'd0, 0, "reset_up2");
        s8(0, 1, 2'b00, 0, 3'd0, 3'd1, 0, "up2_1");
        s8(0, 1, 2'b00, 0, 3'd0, 3'd2, 0, "up2_2");
        s8(0, 1, 2'b00, 0, 3'd0, 3'd3, 0, "up2_3");
        s8(0, 1, 2'b11, 1, 3'd5, 3'd0, 0, "mode_change_john");
        for (int i = 0; i < 6; i++)
            s8(0, 1, 2'b11, 0, 3'd0, john_exp[i], (i == 5), $sformatf("john%0d", i));
        s8(0, 1, 2'b11, 0, 3'd0, 3'b001, 0, "john_restart");
        s8(0, 1, 2'b11, 1, 3'd6, 3'b000, 0, "john_load_zero");

        // Enable gating, load over enable, reset over everything
        s8(1, 0, 2'b00, 0, 3'd0, 3'd0, 0, "reset_en");
        s8(0, 1, 2'b00, 0, 3'd0, 3'd1, 0, "en_on");
        s8(0, 0, 2'b00, 0, 3'd0, 3'd1, 0, "en_off_hold");
        s8(0, 0, 2'b00, 1, 3'd4, 3'd4, 0, "load4");
        s8(0, 1, 2'b00, 0, 3'd0, 3'd5, 0, "en_after_load");
        s8(1, 1, 2'b00, 1, 3'd4, 3'd0, 0, "reset_overrides");

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge CLK);
        if (q.size() > 0) begin
            n_total++;
            $display("FAIL drain: %0d expectations still pending, expected 0", q.size());
        end
        @(negedge CLK);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
